// File: rtl/stop_game_ctrl_if.sv
// Signal bundle between the stop-the-light game controller and its button, position-counter and display neighbours.
// The controller side uses the master modport; the environment/testbench side uses slave.
interface stop_game_ctrl_if #(
   parameter int SCORE_W = 4
);
   logic               btn_start;
   logic               btn_stop;
   logic [3:0]         position;
   logic               start_flag;
   logic [1:0]         state;
   logic [SCORE_W-1:0] score;
   logic [1:0]         lives;
   logic               hit;
   logic               miss;
   logic               game_over;

   // Handshake: btn_start/btn_stop are single-cycle request pulses with no ready
   // (ignored when the current state does not accept them); hit/miss act as the
   // one-cycle valid for a judgement, and score/lives are valid alongside them.
   modport master (
      input  btn_start, btn_stop, position,
      output start_flag, state, score, lives, hit, miss, game_over
   );

   modport slave (
      output btn_start, btn_stop, position,
      input  start_flag, state, score, lives, hit, miss, game_over
   );
endinterface

// File: rtl/stop_game_ctrl.sv
// Game controller for the 9-LED "stop the light" game: judges stop presses
// against a target position, keeps score and lives, and gates the position counter.
module stop_game_ctrl #(
   parameter int TARGET_POS  = 4,
   parameter int HOLD_CYCLES = 100000000,
   parameter int MAX_LIVES   = 3,
   parameter int SCORE_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   stop_game_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_RESULT = 2'd2,
      S_OVER   = 2'd3
   } state_t;

   localparam int                 HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [1:0]         LIVES_INIT = 2'(MAX_LIVES);
   localparam logic [3:0]         TARGET     = 4'(TARGET_POS);

   state_t             st_q, st_n;
   logic [HOLD_W-1:0]  hold_q, hold_n;
   logic [SCORE_W-1:0] score_q, score_n;
   logic [1:0]         lives_q, lives_n;
   logic               hit_q, hit_n;
   logic               miss_q, miss_n;
   logic               start_flag_q, start_flag_n;
   logic               game_over_q, game_over_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q         <= S_IDLE;
         hold_q       <= '0;
         score_q      <= '0;
         lives_q      <= LIVES_INIT;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         start_flag_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         st_q         <= st_n;
         hold_q       <= hold_n;
         score_q      <= score_n;
         lives_q      <= lives_n;
         hit_q        <= hit_n;
         miss_q       <= miss_n;
         start_flag_q <= start_flag_n;
         game_over_q  <= game_over_n;
      end
   end

   always_comb begin
      st_n    = st_q;
      hold_n  = hold_q;
      score_n = score_q;
      lives_n = lives_q;
      hit_n   = 1'b0;
      miss_n  = 1'b0;

      case (st_q)
         S_IDLE, S_OVER: begin
            // A start wins over a simultaneous stop here; stop alone does nothing.
            if (bus.btn_start) begin
               st_n    = S_RUN;
               score_n = '0;
               lives_n = LIVES_INIT;
            end
         end
         S_RUN: begin
            if (bus.btn_stop) begin
               st_n   = S_RESULT;
               hold_n = '0;
               if (bus.position == TARGET) begin
                  hit_n = 1'b1;
                  if (score_q != SCORE_MAX) begin
                     score_n = score_q + SCORE_W'(1);
                  end
               end else begin
                  miss_n  = 1'b1;
                  lives_n = lives_q - 2'd1;
               end
            end
         end
         S_RESULT: begin
            // hold_q counts 0..HOLD_CYCLES-1, so RESULT is visible for HOLD_CYCLES cycles.
            if (hold_q == HOLD_LAST) begin
               st_n = (lives_q == 2'd0) ? S_OVER : S_RUN;
            end else begin
               hold_n = hold_q + HOLD_W'(1);
            end
         end
         default: st_n = S_IDLE;
      endcase

      // Registered so the outputs track the state they describe with no glitch path.
      start_flag_n = (st_n == S_RUN);
      game_over_n  = (st_n == S_OVER);
   end

   assign bus.start_flag = start_flag_q;
   assign bus.state      = st_q;
   assign bus.score      = score_q;
   assign bus.lives      = lives_q;
   assign bus.hit        = hit_q;
   assign bus.miss       = miss_q;
   assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_stop_game_ctrl.sv
// Self-checking bench for stop_game_ctrl: directed scenarios then random play,
// compared every cycle against a behavioural game model plus a judgement scoreboard.
module tb_stop_game_ctrl;
   localparam int TARGET_POS  = 4;
   localparam int HOLD_CYCLES = 4;
   localparam int MAX_LIVES   = 3;
   localparam int SCORE_W     = 2;
   localparam int SCORE_SAT   = (1 << SCORE_W) - 1;
   localparam int W           = 1 + SCORE_W + 2;

   logic clk;
   logic rst_n;

   stop_game_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

   stop_game_ctrl #(
      .TARGET_POS (TARGET_POS),
      .HOLD_CYCLES(HOLD_CYCLES),
      .MAX_LIVES  (MAX_LIVES),
      .SCORE_W    (SCORE_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];

   // Behavioural game model: mode 0 idle, 1 running, 2 showing result, 3 game over.
   int   m_mode  = 0;
   int   m_score = 0;
   int   m_lives = MAX_LIVES;
   int   m_hold  = 0;
   logic m_hit   = 1'b0;
   logic m_miss  = 1'b0;
   logic live    = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode  = 0;
         m_score = 0;
         m_lives = MAX_LIVES;
         m_hold  = 0;
         m_hit   = 1'b0;
         m_miss  = 1'b0;
         exp_q.delete();
         live    = 1'b1;
      end else begin
         m_hit  = 1'b0;
         m_miss = 1'b0;
         if (m_mode == 0 || m_mode == 3) begin
            if (bus.btn_start) begin
               m_mode  = 1;
               m_score = 0;
               m_lives = MAX_LIVES;
            end
         end else if (m_mode == 1) begin
            if (bus.btn_stop) begin
               if (int'(bus.position) == TARGET_POS) begin
                  m_hit   = 1'b1;
                  m_score = (m_score < SCORE_SAT) ? m_score + 1 : SCORE_SAT;
               end else begin
                  m_miss  = 1'b1;
                  m_lives = m_lives - 1;
               end
               m_mode = 2;
               m_hold = HOLD_CYCLES;
               exp_q.push_back({m_hit, SCORE_W'(m_score), 2'(m_lives)});
            end
         end else begin
            m_hold = m_hold - 1;
            if (m_hold == 0) m_mode = (m_lives == 0) ? 3 : 1;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: per-cycle output check plus scoreboard pop on every judgement.
   always @(negedge clk) begin
      if (live) begin
         check("state",      32'(bus.state),      32'(m_mode));
         check("start_flag", 32'(bus.start_flag), 32'(m_mode == 1));
         check("game_over",  32'(bus.game_over),  32'(m_mode == 3));
         check("score",      32'(bus.score),      32'(m_score));
         check("lives",      32'(bus.lives),      32'(m_lives));
         check("hit",        32'(bus.hit),        32'(m_hit));
         check("miss",       32'(bus.miss),       32'(m_miss));
         if (bus.hit || bus.miss) begin
            if (exp_q.size() == 0) begin
               check("judge_unexpected", 32'(1), 32'(0));
            end else begin
               check("judge", 32'({bus.hit, bus.score, bus.lives}), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // Driver tasks
   task automatic drive(input logic s, input logic p, input logic [3:0] pos);
      @(negedge clk);
      bus.btn_start = s;
      bus.btn_stop  = p;
      bus.position  = pos;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      bus.btn_start = 1'b0;
      bus.btn_stop  = 1'b0;
      idle(n - 1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pos;
      rst_n         = 1'b0;
      bus.btn_start = 1'b0;
      bus.btn_stop  = 1'b0;
      bus.position  = 4'd0;
      do_reset(2);
      idle(2);

      // Hit then return to RUN, followed by three misses to game over
      drive(1, 0, 0); idle(2);
      drive(0, 1, 4); idle(6);
      drive(0, 1, 7); idle(5);
      drive(0, 1, 12); idle(5);
      drive(0, 1, 7); idle(7);

      // Restart from OVER with both buttons, five hits for saturation
      drive(1, 1, 7); idle(1);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 4); idle(5);
      end
      // Both buttons in RUN are a stop; presses during RESULT are ignored
      drive(1, 1, 9);
      drive(1, 1, 4); drive(0, 1, 4); drive(1, 0, 2); idle(4);

      // Reset two cycles into RESULT, then a fresh game
      drive(0, 1, 4); idle(1);
      do_reset(1);
      idle(1);
      drive(1, 0, 0); idle(3);

      // Random play
      for (int i = 0; i < 4000; i++) begin
         pos = ($urandom_range(0, 2) == 0) ? 4'(TARGET_POS) : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 599) == 0) begin
            do_reset(1 + $urandom_range(0, 1));
         end else begin
            drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 5) == 0), pos);
         end
      end
      idle(10);
      check("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stop_game_ctrl.md
Name: stop_game_ctrl

Overview:
Game controller for the 9-LED "stop the light" game, paired with the position counter that runs the LED light across positions 0..8. It drives `start_flag` into the position counter, which freezes and clears the light. It consumes the 4-bit position the counter produces. On each stop press it judges hit or miss against a target position and keeps score and lives. Its outputs feed the 7-segment and LED display logic.

Parameters:
- TARGET_POS, 4: position (0..8) that counts as a hit.
- HOLD_CYCLES, 100000000: `clk` cycles spent in RESULT. Must be ≥1; 1 s at 100 MHz.
- MAX_LIVES, 3: lives at game start, range 1..3.
- SCORE_W, 4: width of the score counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- btn_start  in  1  debounced single-cycle start pulse.
- btn_stop  in  1  debounced single-cycle stop pulse.
- position  in  4  current light position from the position counter.
- start_flag  out  1  run enable to the position counter; 0 holds it at position 0.
- state  out  2  encoding: 0 = IDLE, 1 = RUN, 2 = RESULT, 3 = OVER.
- score  out  SCORE_W  hits this game.
- lives  out  2  remaining lives.
- hit  out  1  one-cycle pulse on a correct stop.
- miss  out  1  one-cycle pulse on a wrong stop.
- game_over  out  1  high while in OVER.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (`rst_n` = 0 at a `clk` edge), from any state including mid-game or mid-RESULT:
  - state = IDLE, start_flag = 0, score = 0, lives = MAX_LIVES, hit = 0, miss = 0, game_over = 0, hold counter = 0.
- All outputs are registered.
- start_flag = 1 only in RUN. game_over = 1 only in OVER.
- IDLE:
  - btn_start → RUN at the next edge; score cleared to 0, lives set to MAX_LIVES.
  - btn_stop ignored.
- RUN:
  - btn_stop high in cycle N: position is sampled in cycle N, and the result is visible in cycle N+1.
  - If position == TARGET_POS: hit = 1 for exactly cycle N+1, and score increments, saturating at 2^SCORE_W−1.
  - Otherwise: miss = 1 for exactly cycle N+1, and lives decrements. Position values 9..15 count as a miss.
  - Either way, state = RESULT from cycle N+1 and the hold counter is cleared.
  - btn_start ignored in RUN.
- RESULT:
  - Lasts exactly HOLD_CYCLES cycles, counted by a hold counter of width max(1, clog2(HOLD_CYCLES)).
  - After the last cycle: if lives == 0, go to OVER; otherwise return to RUN.
  - Both buttons ignored.
  - Because start_flag = 0 here, the light restarts from position 0 when RUN resumes.
- OVER:
  - score and lives held for display.
  - btn_start → RUN, with score = 0, lives = MAX_LIVES, game_over = 0 from the next cycle.
  - btn_stop ignored.
- Simultaneous btn_start and btn_stop:
  - In IDLE and OVER, start is taken.
  - In RUN, stop is taken.
  - In RESULT, both are ignored.
- hit and miss are never high in the same cycle.
- Lives never underflow, because RUN is unreachable with lives == 0.
- No combinational path from `position` or the buttons to any output.

Test Plan:
1. Reset: rst_n = 0 for 2 cycles, then 1 → state = 0, start_flag = 0, score = 0, lives = 3, hit = miss = game_over = 0.
2. Hit: HOLD_CYCLES = 4; btn_start; then btn_stop with position = 4 → next cycle hit = 1 (one cycle), score = 1, state = 2, start_flag = 0; exactly 4 cycles later state = 1, start_flag = 1.
3. Three misses: three btn_stop presses with position = 7 → lives 3→2→1→0, three miss pulses; after the third RESULT, state = 3, game_over = 1, score unchanged.
4. Score saturation: SCORE_W = 2; five hits → score sequence 1, 2, 3, 3, 3, hit pulses every time.
5. Simultaneous/ignored presses: btn_start with btn_stop in RUN → judged as a stop; button pulses during RESULT → no change in score, lives or hold length; btn_start in OVER → state = 1, score = 0, lives = 3.
6. Reset mid-RESULT: assert rst_n = 0 two cycles into RESULT → next edge all outputs at reset values; a subsequent btn_start begins a fresh game.
